projectile_controller: RTL and testbench

Player-projectile engine for the invaders game. Launches one projectile from the player ship on a fire press and moves it upward on a divided step tick. Each cycle it tests the projectile against the enemy grid anchored at the fleet's enemy_h/enemy_v, and keeps the per-enemy alive mask. Drives projectile_h/projectile_v into the enemy fleet and the renderer, and reports hits, fleet clearance and, optionally, score.

---
 rtl/game_pkg.sv | 26 ++
 rtl/fleet_hit_locator.sv | 63 ++++++
 rtl/projectile_controller.sv | 212 +++++++++++++++++++++
 tb/tb_projectile_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared invaders game types, fleet geometry and projectile defaults
package game_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_READY  = 2'd1,
        ST_FLYING = 2'd2,
        ST_HIT    = 2'd3
    } proj_state_e;

    localparam int DEF_STEP_DIV   = 262144;
    localparam int DEF_PROJ_SPEED = 4;
    localparam int DEF_LAUNCH_V   = 450;
    localparam int DEF_TOP_LIMIT  = 35;

    // Fleet geometry, shared with the enemy fleet mover
    localparam int DEF_COLS      = 6;
    localparam int DEF_ROWS      = 3;
    localparam int DEF_SPACING_H = 50;
    localparam int DEF_SPACING_V = 50;
    localparam int DEF_ENEMY_W   = 30;
    localparam int DEF_ENEMY_HT  = 20;

    localparam int DEF_POINTS = 10;

endpackage

// File: rtl/fleet_hit_locator.sv
// rtl/fleet_hit_locator.sv - combinational projectile-to-fleet cell locator using unrolled range compares
module fleet_hit_locator
    import game_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int SPACING_H = DEF_SPACING_H,
    parameter int SPACING_V = DEF_SPACING_V,
    parameter int ENEMY_W   = DEF_ENEMY_W,
    parameter int ENEMY_HT  = DEF_ENEMY_HT
) (
    input  logic [9:0]           projectile_h,
    input  logic [9:0]           projectile_v,
    input  logic [9:0]           enemy_h,
    input  logic [9:0]           enemy_v,
    input  logic [COLS*ROWS-1:0] alive_mask,
    output logic                 in_cell,
    output logic [2:0]           col,
    output logic [1:0]           row,
    output logic                 alive
);

    logic [10:0]           dx;
    logic [10:0]           dy;
    logic [COLS-1:0]       col_ok;
    logic [ROWS-1:0]       row_ok;
    logic [COLS*ROWS-1:0]  cell_hit;
    logic [2:0]            col_acc [COLS+1];
    logic [1:0]            row_acc [ROWS+1];

    // Bit 10 of the 11-bit difference is the sign: projectile left of / above the anchor
    assign dx = {1'b0, projectile_h} - {1'b0, enemy_h};
    assign dy = {1'b0, projectile_v} - {1'b0, enemy_v};

    assign col_acc[0] = 3'd0;
    assign row_acc[0] = 2'd0;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [11:0] off;
        assign off           = {1'b0, dx} - 12'(c * SPACING_H);
        assign col_ok[c]     = ~dx[10] & ~off[11] & (off[10:0] < 11'(ENEMY_W));
        assign col_acc[c+1]  = col_acc[c] | (col_ok[c] ? 3'(c) : 3'd0);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [11:0] off;
        assign off           = {1'b0, dy} - 12'(r * SPACING_V);
        assign row_ok[r]     = ~dy[10] & ~off[11] & (off[10:0] < 11'(ENEMY_HT));
        assign row_acc[r+1]  = row_acc[r] | (row_ok[r] ? 2'(r) : 2'd0);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_cell_r
        for (genvar c = 0; c < COLS; c++) begin : g_cell_c
            assign cell_hit[r*COLS+c] = row_ok[r] & col_ok[c];
        end
    end

    assign in_cell = |cell_hit;
    assign col     = col_acc[COLS];
    assign row     = row_acc[ROWS];
    assign alive   = |(cell_hit & alive_mask);

endmodule

// File: rtl/projectile_controller.sv
// rtl/projectile_controller.sv - player projectile launch, flight and fleet hit tracking; SCORE_EN adds the score port
module projectile_controller
    import game_pkg::*;
#(
    parameter int STEP_DIV   = DEF_STEP_DIV,
    parameter int PROJ_SPEED = DEF_PROJ_SPEED,
    parameter int LAUNCH_V   = DEF_LAUNCH_V,
    parameter int TOP_LIMIT  = DEF_TOP_LIMIT,
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int SPACING_H  = DEF_SPACING_H,
    parameter int SPACING_V  = DEF_SPACING_V,
    parameter int ENEMY_W    = DEF_ENEMY_W,
    parameter int ENEMY_HT   = DEF_ENEMY_HT,
    parameter int POINTS     = DEF_POINTS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 playing,
    input  logic                 fire,
    input  logic [9:0]           ship_h,
    input  logic [9:0]           enemy_h,
    input  logic [9:0]           enemy_v,
    output logic [9:0]           projectile_h,
    output logic [9:0]           projectile_v,
    output logic                 projectile_active,
    output logic                 hit,
    output logic [2:0]           hit_col,
    output logic [1:0]           hit_row,
    output logic [COLS*ROWS-1:0] alive_mask,
    output logic                 fleet_cleared
`ifdef SCORE_EN
    ,
    output logic [15:0]          score
`endif
);

    localparam int               CNT_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int               N_ENEMY    = COLS * ROWS;
    localparam logic [9:0]       PARK_LIMIT = 10'(TOP_LIMIT + PROJ_SPEED);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_DIV - 1);

    proj_state_e          state_q, state_d;
    logic [9:0]           ph_q, ph_d;
    logic [9:0]           pv_q, pv_d;
    logic                 act_q, act_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 hit_q, hit_d;
    logic [2:0]           hc_q, hc_d;
    logic [1:0]           hr_q, hr_d;
    logic [N_ENEMY-1:0]   alive_q, alive_d;
    logic                 clr_q, clr_d;
    logic                 fire_prev_q, fire_prev_d;
`ifdef SCORE_EN
    logic [15:0]          score_q, score_d;
`endif

    logic                 fire_edge;
    logic                 loc_in_cell;
    logic                 loc_alive;
    logic [2:0]           loc_col;
    logic [1:0]           loc_row;
    logic                 loc_hit;

    fleet_hit_locator #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .SPACING_H (SPACING_H),
        .SPACING_V (SPACING_V),
        .ENEMY_W   (ENEMY_W),
        .ENEMY_HT  (ENEMY_HT)
    ) u_locator (
        .projectile_h (ph_q),
        .projectile_v (pv_q),
        .enemy_h      (enemy_h),
        .enemy_v      (enemy_v),
        .alive_mask   (alive_q),
        .in_cell      (loc_in_cell),
        .col          (loc_col),
        .row          (loc_row),
        .alive        (loc_alive)
    );

    assign fire_edge = fire & ~fire_prev_q;
    assign loc_hit   = loc_in_cell & loc_alive;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        pv_d        = pv_q;
        act_d       = act_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        hc_d        = hc_q;
        hr_d        = hr_q;
        alive_d     = alive_q;
        clr_d       = clr_q;
        fire_prev_d = fire;
`ifdef SCORE_EN
        score_d     = score_q;
`endif

        if (start || state_q == ST_INIT) begin
            state_d = (!start && playing) ? ST_READY : ST_INIT;
            ph_d    = '0;
            pv_d    = '0;
            act_d   = 1'b0;
            alive_d = '1;
            clr_d   = 1'b0;
`ifdef SCORE_EN
            score_d = '0;
`endif
        end else begin
            case (state_q)
                ST_READY: begin
                    if (fire_edge && playing) begin
                        ph_d    = ship_h;
                        pv_d    = 10'(LAUNCH_V);
                        act_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_FLYING;
                    end
                end
                ST_FLYING: begin
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                    if (!playing) begin
                        ph_d    = '0;
                        pv_d    = '0;
                        act_d   = 1'b0;
                        state_d = ST_READY;
                    end else if (loc_hit) begin
                        // Hit wins over a coincident step tick
                        hit_d   = 1'b1;
                        hc_d    = loc_col;
                        hr_d    = loc_row;
                        alive_d = alive_q & ~(N_ENEMY'(1) << (int'(loc_row) * COLS + int'(loc_col)));
                        ph_d    = '0;
                        pv_d    = '0;
                        act_d   = 1'b0;
                        state_d = ST_HIT;
`ifdef SCORE_EN
                        score_d = (score_q > 16'(16'hFFFF - POINTS)) ? 16'hFFFF
                                                                      : score_q + 16'(POINTS);
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        if (pv_q <= PARK_LIMIT) begin
                            ph_d    = '0;
                            pv_d    = '0;
                            act_d   = 1'b0;
                            state_d = ST_READY;
                        end else begin
                            pv_d = pv_q - 10'(PROJ_SPEED);
                        end
                    end
                end
                ST_HIT: begin
                    if (alive_q == '0) clr_d = 1'b1;
                    state_d = ST_READY;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            ph_q        <= '0;
            pv_q        <= '0;
            act_q       <= 1'b0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            hc_q        <= '0;
            hr_q        <= '0;
            alive_q     <= '1;
            clr_q       <= 1'b0;
            fire_prev_q <= 1'b0;
`ifdef SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            pv_q        <= pv_d;
            act_q       <= act_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            hc_q        <= hc_d;
            hr_q        <= hr_d;
            alive_q     <= alive_d;
            clr_q       <= clr_d;
            fire_prev_q <= fire_prev_d;
`ifdef SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    assign projectile_h      = ph_q;
    assign projectile_v      = pv_q;
    assign projectile_active = act_q;
    assign hit               = hit_q;
    assign hit_col           = hc_q;
    assign hit_row           = hr_q;
    assign alive_mask        = alive_q;
    assign fleet_cleared     = clr_q;
`ifdef SCORE_EN
    assign score             = score_q;
`endif

endmodule

// File: tb/tb_projectile_controller.sv
// tb/tb_projectile_controller.sv - self-checking bench: shot table, hand sequences, random run against a reference model
module tb_projectile_controller;

    localparam int STEP = 4;
    localparam int M_INIT = 0, M_READY = 1, M_FLY = 2, M_HIT = 3;

    logic        clk = 1'b0;
    logic        reset_n, start, playing, fire;
    logic [9:0]  ship_h, enemy_h, enemy_v;
    logic [9:0]  projectile_h, projectile_v;
    logic        projectile_active, hit, fleet_cleared;
    logic [2:0]  hit_col;
    logic [1:0]  hit_row;
    logic [17:0] alive_mask;
`ifdef SCORE_EN
    logic [15:0] score;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_mode, m_cnt, m_score;
    logic [9:0]  m_h, m_v;
    logic        m_act, m_hit, m_clr, m_fprev;
    logic [2:0]  m_hc;
    logic [1:0]  m_hr;
    logic [17:0] m_alive;

    typedef struct {
        int          ship;
        bit          exp_hit;
        int          col;
        int          row;
        int          v;
        logic [17:0] mask;
    } shot_t;

    shot_t shots [7];

    always #5 clk = ~clk;

    projectile_controller #(.STEP_DIV(STEP)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .playing           (playing),
        .fire              (fire),
        .ship_h            (ship_h),
        .enemy_h           (enemy_h),
        .enemy_v           (enemy_v),
        .projectile_h      (projectile_h),
        .projectile_v      (projectile_v),
        .projectile_active (projectile_active),
        .hit               (hit),
        .hit_col           (hit_col),
        .hit_row           (hit_row),
        .alive_mask        (alive_mask),
        .fleet_cleared     (fleet_cleared)
`ifdef SCORE_EN
        ,
        .score             (score)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic model_park();
        m_h = '0; m_v = '0; m_act = 1'b0;
    endtask

    task automatic model_init();
        model_park();
        m_alive = '1; m_clr = 1'b0; m_score = 0;
    endtask

    // Next state of the game rules, using division and modulo for the grid geometry
    task automatic model_step();
        int dx, dy, c, r;
        bit fe, can_hit;
        if (!reset_n) begin
            model_init();
            m_mode = M_INIT; m_cnt = 0; m_hit = 1'b0; m_hc = '0; m_hr = '0; m_fprev = 1'b0;
            return;
        end
        fe = fire && !m_fprev;
        m_fprev = fire;
        dx = int'(m_h) - int'(enemy_h);
        dy = int'(m_v) - int'(enemy_v);
        can_hit = 1'b0;
        c = 0; r = 0;
        if (m_mode == M_FLY && dx >= 0 && dy >= 0) begin
            c = dx / 50; r = dy / 50;
            if (c < 6 && r < 3 && dx % 50 < 30 && dy % 50 < 20) can_hit = m_alive[r*6+c];
        end
        m_hit = 1'b0;
        if (start) begin
            model_init(); m_mode = M_INIT;
        end else begin
            case (m_mode)
                M_INIT: begin
                    model_init();
                    if (playing) m_mode = M_READY;
                end
                M_READY: if (fe && playing) begin
                    m_h = ship_h; m_v = 10'd450; m_act = 1'b1; m_cnt = 0; m_mode = M_FLY;
                end
                M_FLY: begin
                    bit tick_now;
                    tick_now = (m_cnt == STEP - 1);
                    m_cnt = (m_cnt + 1) % STEP;
                    if (!playing) begin
                        model_park(); m_mode = M_READY;
                    end else if (can_hit) begin
                        m_hit = 1'b1; m_hc = 3'(c); m_hr = 2'(r);
                        m_alive[r*6+c] = 1'b0;
                        model_park();
                        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
                        m_mode = M_HIT;
                    end else if (tick_now) begin
                        if (m_v <= 10'd39) begin
                            model_park(); m_mode = M_READY;
                        end else m_v = m_v - 10'd4;
                    end
                end
                default: begin
                    if (m_alive == '0) m_clr = 1'b1;
                    m_mode = M_READY;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        logic [63:0] got, exp;
`ifdef SCORE_EN
        got = 64'({score, projectile_h, projectile_v, projectile_active, hit, hit_col, hit_row,
                   alive_mask, fleet_cleared});
        exp = 64'({16'(m_score), m_h, m_v, m_act, m_hit, m_hc, m_hr, m_alive, m_clr});
`else
        got = 64'({projectile_h, projectile_v, projectile_active, hit, hit_col, hit_row,
                   alive_mask, fleet_cleared});
        exp = 64'({m_h, m_v, m_act, m_hit, m_hc, m_hr, m_alive, m_clr});
`endif
        check("model", got, exp);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic launch(input logic [9:0] h);
        ship_h = h;
        fire = 1'b0; tick();
        fire = 1'b1; tick();
        fire = 1'b0;
    endtask

    task automatic run_shot(input int i);
        int hits, last_v, got_col, got_row;
        bit done;
        launch(10'(shots[i].ship));
        check("launch_h", 64'(projectile_h), 64'(shots[i].ship));
        check("launch_v", 64'(projectile_v), 64'(450));
        hits = 0; last_v = 450; done = 1'b0; got_col = 0; got_row = 0;
        for (int k = 0; k < 700 && !done; k++) begin
            tick();
            if (hit) begin
                hits++; got_col = int'(hit_col); got_row = int'(hit_row); done = 1'b1;
            end else if (!projectile_active) done = 1'b1;
            else last_v = int'(projectile_v);
        end
        check("shot_done", 64'(done), 64'(1));
        check("shot_hits", 64'(hits), 64'(shots[i].exp_hit));
        check("shot_last_v", 64'(last_v), 64'(shots[i].v));
        tick();
        check("hit_width", 64'(hit), 64'(0));
        check("shot_mask", 64'(alive_mask), 64'(shots[i].mask));
        if (shots[i].exp_hit) begin
            check("hit_col", 64'(got_col), 64'(shots[i].col));
            check("hit_row", 64'(got_row), 64'(shots[i].row));
        end
    endtask

    initial begin
        int launches, hits;
        bit prev_act, done;

        shots[0] = '{190, 1'b1, 0, 2, 182, 18'h3EFFF};
        shots[1] = '{210, 1'b0, 0, 0, 38,  18'h3EFFF};
        shots[2] = '{190, 1'b1, 0, 1, 134, 18'h3EFBF};
        shots[3] = '{440, 1'b1, 5, 2, 182, 18'h1EFBF};
        shots[4] = '{426, 1'b1, 5, 1, 134, 18'h1E7BF};
        shots[5] = '{170, 1'b0, 0, 0, 38,  18'h1E7BF};
        shots[6] = '{254, 1'b1, 1, 2, 182, 18'h1C7BF};

        reset_n = 1'b0; start = 1'b0; playing = 1'b0; fire = 1'b0;
        ship_h = '0; enemy_h = 10'd175; enemy_v = 10'd65;
        repeat (3) tick();
        check("rst_mask", 64'(alive_mask), 64'(18'h3FFFF));
        check("rst_outs", 64'({projectile_h, projectile_v, projectile_active, hit, hit_col,
                               hit_row, fleet_cleared}), 64'(0));

        reset_n = 1'b1; playing = 1'b1; start = 1'b1; tick();
        start = 1'b0; tick();

        for (int i = 0; i < 7; i++) run_shot(i);

        // Held fire: a single launch, then a relaunch only after release
        ship_h = 10'd330; fire = 1'b1; launches = 0; prev_act = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            tick();
            if (projectile_active && !prev_act) launches++;
            prev_act = projectile_active;
        end
        check("held_launches", 64'(launches), 64'(1));
        check("held_mask", 64'(alive_mask), 64'(18'h147BF));
        fire = 1'b0; tick();
        fire = 1'b1; tick();
        check("relaunch", 64'(projectile_active), 64'(1));
        fire = 1'b0;
        repeat (20) tick();
`ifdef SCORE_EN
        check("score_before_start", 64'(score), 64'(60));
`endif
        start = 1'b1; tick();
        start = 1'b0;
        check("start_active", 64'(projectile_active), 64'(0));
        check("start_pos", 64'({projectile_h, projectile_v}), 64'(0));
        check("start_mask", 64'(alive_mask), 64'(18'h3FFFF));
`ifdef SCORE_EN
        check("start_score", 64'(score), 64'(0));
`endif
        tick();

        // Clear the whole fleet: anchor placed so each cell covers the launch point
        hits = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 6; c++) begin
                enemy_h = 10'd175; enemy_v = 10'(440 - r * 50);
                launch(10'(175 + c * 50 + 10));
                tick();
                if (hit) hits++;
                tick();
            end
        end
        check("clear_hits", 64'(hits), 64'(18));
        check("clear_mask", 64'(alive_mask), 64'(0));
        check("fleet_cleared", 64'(fleet_cleared), 64'(1));
`ifdef SCORE_EN
        check("clear_score", 64'(score), 64'(180));
`endif
        launch(10'd200);
        check("post_clear_launch", 64'(projectile_active), 64'(1));
        hits = 0; done = 1'b0;
        for (int k = 0; k < 700 && !done; k++) begin
            tick();
            if (hit) hits++;
            if (!projectile_active) done = 1'b1;
        end
        check("post_clear_done", 64'(done), 64'(1));
        check("post_clear_hits", 64'(hits), 64'(0));

        // Random play against the reference model
        enemy_h = 10'd175; enemy_v = 10'd65;
        start = 1'b1; tick();
        start = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (k % 512 == 0) begin
                enemy_h = 10'($urandom_range(100, 300));
                enemy_v = 10'($urandom_range(40, 200));
            end
            ship_h  = 10'($urandom_range(150, 500));
            fire    = ($urandom_range(0, 7) == 0);
            playing = ($urandom_range(0, 1999) != 0);
            start   = ($urandom_range(0, 2999) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
